// File: rtl/adder.sv
// Ripple-carry adder built from 1-bit full-adder slices, with an optional
// output register. {C_out, o_S} = i_A + i_B + C_in, modulo 2^(n+1).
module adder #(
    parameter int unsigned n       = 1,
    parameter int unsigned REG_OUT = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [n-1:0] i_A,
    input  logic [n-1:0] i_B,
    input  logic         C_in,
    output logic         C_out,
    output logic [n-1:0] o_S
);

    localparam int unsigned RES_W = n + 1;

    logic [n:0]       carry;
    logic [n-1:0]     sum_bits;
    logic [RES_W-1:0] sum_d;
    logic [RES_W-1:0] sum_q;

    // Carry chain: one full-adder slice per bit, carry rippling from bit 0 upward.
    always_comb begin
        carry    = '0;
        sum_bits = '0;
        carry[0] = C_in;
        for (int unsigned k = 0; k < n; k++) begin
            sum_bits[k] = i_A[k] ^ i_B[k] ^ carry[k];
            carry[k+1]  = (i_A[k] & i_B[k]) | (carry[k] & (i_A[k] ^ i_B[k]));
        end
    end

    always_comb begin
        sum_d = {carry[n], sum_bits};
    end

    // Output register; pruned by synthesis when outputs are combinational.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign {C_out, o_S} = (REG_OUT != 0) ? sum_q : sum_d;

endmodule

// File: tb/tb_adder.sv
// Directed and random checks of the adder in combinational (n=1,4,8) and
// registered (n=4) builds.
module tb_adder;

    logic clk;
    logic rst;

    logic       a1, b1, c1, co1, s1;
    logic [3:0] a4, b4, s4;
    logic       c4, co4;
    logic [3:0] ar, br, sr;
    logic       cr, cor;
    logic [7:0] a8, b8, s8;
    logic       c8, co8;

    int total;
    int bad;

    adder #(.n(1), .REG_OUT(0)) u_n1 (
        .i_clk(clk), .i_rst(rst), .i_A(a1), .i_B(b1), .C_in(c1), .C_out(co1), .o_S(s1)
    );
    adder #(.n(4), .REG_OUT(0)) u_n4 (
        .i_clk(clk), .i_rst(rst), .i_A(a4), .i_B(b4), .C_in(c4), .C_out(co4), .o_S(s4)
    );
    adder #(.n(4), .REG_OUT(1)) u_r4 (
        .i_clk(clk), .i_rst(rst), .i_A(ar), .i_B(br), .C_in(cr), .C_out(cor), .o_S(sr)
    );
    adder #(.n(8), .REG_OUT(0)) u_n8 (
        .i_clk(clk), .i_rst(rst), .i_A(a8), .i_B(b8), .C_in(c8), .C_out(co8), .o_S(s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // n=1 vectors as {A,B,Cin} with hand-computed {Cout,S}
    logic [2:0] vec1 [8];
    logic [1:0] exp1 [8];
    // n=4 vectors: A, B, Cin, expected {Cout,S}
    logic [3:0] va4  [5];
    logic [3:0] vb4  [5];
    logic       vc4  [5];
    logic [4:0] ve4  [5];

    initial begin
        logic [8:0] exp8;
        total = 0;
        bad   = 0;

        vec1 = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        exp1 = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};
        va4  = '{4'hF, 4'h5, 4'h3, 4'hF, 4'hF};
        vb4  = '{4'h1, 4'hA, 4'h4, 4'hF, 4'h0};
        vc4  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ve4  = '{5'h10, 5'h10, 5'h07, 5'h1F, 5'h10};

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = '0;   b4 = '0;   c4 = 1'b0;
        ar = 4'hF; br = 4'hF; cr = 1'b1;
        a8 = '0;   b8 = '0;   c8 = 1'b0;

        #1;
        check("reset_r4", 32'({cor, sr}), 32'h0);

        // n=1 exhaustive: apply on a posedge, check on the next one
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            {a1, b1, c1} = vec1[i];
            @(posedge clk);
            #1;
            check($sformatf("n1_%0d", i), 32'({co1, s1}), 32'(exp1[i]));
        end

        // n=4 combinational, including wrap and all-ones boundaries
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = va4[i]; b4 = vb4[i]; c4 = vc4[i];
            #1;
            check($sformatf("n4_%0d", i), 32'({co4, s4}), 32'(ve4[i]));
        end

        // reset held across an edge keeps registered outputs at zero
        @(posedge clk);
        #1;
        check("reset_hold_r4", 32'({cor, sr}), 32'h0);

        // release reset: no capture until the next posedge
        @(negedge clk);
        rst = 1'b0;
        ar = 4'h3; br = 4'h4; cr = 1'b0;
        #1;
        check("r4_before_first_edge", 32'({cor, sr}), 32'h0);
        @(posedge clk);
        #1;
        check("r4_first_capture", 32'({cor, sr}), 32'h07);

        // 9+8+1: old value held until the edge, then 5'h12
        @(negedge clk);
        ar = 4'h9; br = 4'h8; cr = 1'b1;
        #1;
        check("r4_hold_old", 32'({cor, sr}), 32'h07);
        @(posedge clk);
        #1;
        check("r4_9_8_1", 32'({cor, sr}), 32'h12);

        // asynchronous reset between edges discards the in-flight sum
        @(negedge clk);
        ar = 4'h1; br = 4'h1; cr = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("r4_async_reset", 32'({cor, sr}), 32'h0);
        @(posedge clk);
        #1;
        check("r4_reset_across_edge", 32'({cor, sr}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("r4_after_release", 32'({cor, sr}), 32'h0);
        @(posedge clk);
        #1;
        check("r4_reload", 32'({cor, sr}), 32'h02);

        // n=8 boundaries
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        check("n8_all_ones", 32'({co8, s8}), 32'h1FF);
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #1;
        check("n8_wrap", 32'({co8, s8}), 32'h100);

        // n=8 random regression against integer addition
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(255));
            b8 = 8'($urandom_range(255));
            c8 = 1'($urandom_range(1));
            #1;
            exp8 = 9'(a8) + 9'(b8) + 9'(c8);
            check($sformatf("n8_rand_%0d", i), 32'({co8, s8}), 32'(exp8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
